phase_step_sweep_controller: RTL and testbench

- Upstream stage of sine_wave_generator_quarter. Drives its 32-bit phase_step input with a programmable linear frequency sweep.
- A sweep runs from start_step to stop_step in step_increment increments. Each value is held for dwell_cycles clocks.
- Replaces bench-side sweep loops so hardware and simulation share one sweep engine. Reports busy/done to system control.

---
 rtl/phase_step_sweep_controller_if.sv | 29 ++
 rtl/phase_step_sweep_controller.sv | 116 +++++++++++
 tb/tb_phase_step_sweep_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_step_sweep_controller_if.sv
// Bus between the sweep controller and its system-control / tone-generator neighbours.
// start is a one-cycle request, accepted only while the controller is idle; there is no ready.
interface phase_step_sweep_controller_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 32,
  parameter int INDEX_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic [PHASE_WIDTH-1:0] start_step;
  logic [PHASE_WIDTH-1:0] stop_step;
  logic [PHASE_WIDTH-1:0] step_increment;
  logic [DWELL_WIDTH-1:0] dwell_cycles;
  logic [PHASE_WIDTH-1:0] phase_step;
  logic                   busy;
  logic                   done;
  logic [INDEX_WIDTH-1:0] step_index;
  logic [1:0]             state;

  modport master (
    output start, abort, start_step, stop_step, step_increment, dwell_cycles,
    input  phase_step, busy, done, step_index, state
  );

  modport slave (
    input  start, abort, start_step, stop_step, step_increment, dwell_cycles,
    output phase_step, busy, done, step_index, state
  );
endinterface

// File: rtl/phase_step_sweep_controller.sv
// Linear phase_step sweep engine feeding sine_wave_generator_quarter.
// Optional PHASE_STEP_SWEEP_CONTINUOUS_EN: restart the sweep at its end instead of stopping.
module phase_step_sweep_controller #(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 32,
  parameter int INDEX_WIDTH = 16
) (
  input logic                        clock,
  input logic                        reset_n,
  phase_step_sweep_controller_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DWELL   = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic                   busy_q;
  logic                   done_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [DWELL_WIDTH-1:0] count_q;
  logic [PHASE_WIDTH-1:0] start_l;
  logic [PHASE_WIDTH-1:0] stop_l;
  logic [PHASE_WIDTH-1:0] inc_l;
  logic [DWELL_WIDTH-1:0] dwell_l;

  logic [PHASE_WIDTH:0]   next_wide;
  logic                   sweep_end;
  logic [DWELL_WIDTH-1:0] dwell_reload;
  logic [DWELL_WIDTH-1:0] start_reload;
  logic [INDEX_WIDTH-1:0] index_inc;

  // The extra carry bit means an overflowing step always lands above stop_l;
  // a sweep that started above stop_l also ends here since next > phase > stop.
  always_comb begin
    next_wide    = {1'b0, phase_q} + {1'b0, inc_l};
    sweep_end    = (inc_l == '0) || (next_wide > {1'b0, stop_l});
    dwell_reload = (dwell_l == '0) ? '0 : dwell_l - 1'b1;
    start_reload = (bus.dwell_cycles == '0) ? '0 : bus.dwell_cycles - 1'b1;
    index_inc    = (&index_q) ? index_q : index_q + 1'b1;
  end

  // count_q holds the dwell cycles remaining after the current one; ADVANCE is
  // the last dwell cycle of each value, so evaluation costs no extra cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      index_q <= '0;
      count_q <= '0;
      start_l <= '0;
      stop_l  <= '0;
      inc_l   <= '0;
      dwell_l <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        state_q <= IDLE;
        phase_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            phase_q <= '0;
            if (bus.start && !bus.abort) begin
              start_l <= bus.start_step;
              stop_l  <= bus.stop_step;
              inc_l   <= bus.step_increment;
              dwell_l <= bus.dwell_cycles;
              phase_q <= bus.start_step;
              busy_q  <= 1'b1;
              index_q <= '0;
              count_q <= start_reload;
              state_q <= (start_reload == '0) ? ADVANCE : DWELL;
            end
          end
          DWELL: begin
            count_q <= count_q - 1'b1;
            if (count_q == DWELL_WIDTH'(1)) state_q <= ADVANCE;
          end
          ADVANCE: begin
            if (!sweep_end) begin
              phase_q <= next_wide[PHASE_WIDTH-1:0];
              index_q <= index_inc;
              count_q <= dwell_reload;
              state_q <= (dwell_reload == '0) ? ADVANCE : DWELL;
            end else begin
              done_q <= 1'b1;
`ifdef PHASE_STEP_SWEEP_CONTINUOUS_EN
              phase_q <= start_l;
              index_q <= '0;
              count_q <= dwell_reload;
              state_q <= (dwell_reload == '0) ? ADVANCE : DWELL;
`else
              phase_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.phase_step = phase_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_index = index_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_phase_step_sweep_controller.sv
// Self-checking bench for phase_step_sweep_controller: table vectors, corner sequences, random sweeps.
module tb_phase_step_sweep_controller;
  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  phase_step_sweep_controller_if bus ();

  phase_step_sweep_controller dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [15:0] exp_idx_q[$];

  typedef struct {
    logic [31:0] start_step;
    logic [31:0] stop_step;
    logic [31:0] inc;
    logic [31:0] dwell;
    int          exp_cycles;
    logic [15:0] exp_last_idx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected value sequence, one entry per clock the sweep is busy.
  task automatic build_model(input logic [31:0] s, input logic [31:0] p,
                             input logic [31:0] inc, input logic [31:0] d);
    longint unsigned v   = s;
    longint unsigned eff = (d == 0) ? 1 : d;
    int idx = 0;
    exp_q.delete();
    exp_idx_q.delete();
    forever begin
      for (longint unsigned k = 0; k < eff; k++) begin
        exp_q.push_back(v[31:0]);
        exp_idx_q.push_back(idx[15:0]);
      end
      if (s > p || inc == 0 || v + inc > p) break;
      v = v + inc;
      if (idx < 65535) idx++;
    end
  endtask

  task automatic drive_cfg(input logic [31:0] s, input logic [31:0] p,
                           input logic [31:0] inc, input logic [31:0] d);
    bus.start_step     = s;
    bus.stop_step      = p;
    bus.step_increment = inc;
    bus.dwell_cycles   = d;
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] p,
                           input logic [31:0] inc, input logic [31:0] d,
                           input int abort_at, input int restart_at,
                           input bit skip_start, input bit chain,
                           output int busy_cycles);
    build_model(s, p, inc, d);
    busy_cycles = 0;
    if (!skip_start) begin
      @(negedge clock);
      drive_cfg(s, p, inc, d);
      bus.start = 1'b1;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      bus.start = (i == restart_at);
      if (i == 0 || i == restart_at)
        drive_cfg($urandom, $urandom, $urandom, $urandom_range(0, 9));
      check("phase_step", bus.phase_step, exp_q[i]);
      check("busy", bus.busy, 1'b1);
      check("done_early", bus.done, 1'b0);
      check("step_index", bus.step_index, exp_idx_q[i]);
      if (bus.busy) busy_cycles++;
      if (i == abort_at) begin
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        check("abort_phase", bus.phase_step, 0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        @(negedge clock);
        check("abort_done_after", bus.done, 1'b0);
        check("abort_busy_after", bus.busy, 1'b0);
        return;
      end
    end
    @(negedge clock);
    bus.start = 1'b0;
`ifdef PHASE_STEP_SWEEP_CONTINUOUS_EN
    check("wrap_phase", bus.phase_step, s);
    check("wrap_busy", bus.busy, 1'b1);
    check("wrap_done", bus.done, 1'b1);
    check("wrap_index", bus.step_index, 0);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("stop_phase", bus.phase_step, 0);
    check("stop_busy", bus.busy, 1'b0);
    check("stop_done", bus.done, 1'b0);
`else
    check("end_phase", bus.phase_step, 0);
    check("end_busy", bus.busy, 1'b0);
    check("end_done", bus.done, 1'b1);
    check("end_index", bus.step_index, exp_idx_q[exp_idx_q.size()-1]);
    if (!chain) begin
      @(negedge clock);
      check("idle_done", bus.done, 1'b0);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_phase", bus.phase_step, 0);
    end
`endif
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive_cfg(0, 0, 0, 0);

    vecs[0] = '{32'd0,          32'd3000,     32'd1000,    32'd4, 16, 16'd3};
    vecs[1] = '{32'hFFFF_F000,  32'hFFFF_FFFF, 32'h1000,   32'd2, 2,  16'd0};
    vecs[2] = '{32'd10,         32'd12,       32'd1,       32'd0, 3,  16'd2};
    vecs[3] = '{32'd500,        32'd100,      32'd7,       32'd3, 3,  16'd0};
    vecs[4] = '{32'd42,         32'd1000,     32'd0,       32'd5, 5,  16'd0};
    vecs[5] = '{32'd100,        32'd100,      32'd1,       32'd2, 2,  16'd0};
    vecs[6] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'd1,      32'd1, 2,  16'd1};

    #1 reset_n = 1'b0;
    #3;
    check("reset_phase", bus.phase_step, 0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_index", bus.step_index, 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[v]) begin
      run_sweep(vecs[v].start_step, vecs[v].stop_step, vecs[v].inc, vecs[v].dwell,
                -1, -1, 1'b0, 1'b0, cyc);
      check("busy_cycles", cyc, vecs[v].exp_cycles);
      check("table_last_index", exp_idx_q[exp_idx_q.size()-1], vecs[v].exp_last_idx);
    end

    // Abort on the third cycle of value 2000 (11th busy cycle).
    run_sweep(0, 3000, 1000, 4, 10, -1, 1'b0, 1'b0, cyc);

    @(negedge clock);
    drive_cfg(0, 3000, 1000, 4);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 1'b0);
    check("start_abort_phase", bus.phase_step, 0);
    @(negedge clock);
    check("start_abort_busy2", bus.busy, 1'b0);

    // start pulsed mid-sweep must not disturb it.
    run_sweep(0, 3000, 1000, 4, -1, 6, 1'b0, 1'b0, cyc);
    check("restart_busy_cycles", cyc, 16);

`ifndef PHASE_STEP_SWEEP_CONTINUOUS_EN
    // start in the done cycle is accepted.
    run_sweep(10, 12, 1, 0, -1, -1, 1'b0, 1'b1, cyc);
    drive_cfg(0, 3000, 1000, 4);
    bus.start = 1'b1;
    run_sweep(0, 3000, 1000, 4, -1, -1, 1'b1, 1'b0, cyc);
    check("chain_busy_cycles", cyc, 16);
`endif

    // Asynchronous reset mid-sweep.
    @(negedge clock);
    drive_cfg(0, 3000, 1000, 4);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_phase", bus.phase_step, 0);
    check("async_reset_busy", bus.busy, 1'b0);
    check("async_reset_done", bus.done, 1'b0);
    check("async_reset_index", bus.step_index, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_sweep(0, 3000, 1000, 4, -1, -1, 1'b0, 1'b0, cyc);
    check("post_reset_busy_cycles", cyc, 16);

    for (int r = 0; r < 25; r++) begin
      longint unsigned s64, inc64, stop64;
      logic [31:0] p;
      s64   = $urandom;
      inc64 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1 << 20);
      stop64 = s64 + inc64 * $urandom_range(0, 4) + ((inc64 > 0) ? $urandom_range(0, inc64 - 1) : 0);
      if (stop64 > 64'hFFFF_FFFF) stop64 = 64'hFFFF_FFFF;
      p = stop64[31:0];
      if ($urandom_range(0, 5) == 0) p = (s64 > 0) ? s64[31:0] - 1 : 32'd0;
      run_sweep(s64[31:0], p, inc64[31:0], $urandom_range(0, 5), -1, -1, 1'b0, 1'b0, cyc);
      check("rand_busy_cycles", cyc, exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
